// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for fifo_wr_arbiter.
// The master drives the requests and the FIFO full flag; the arbiter (slave) drives acks and the write port.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       last;
  logic [NUM_REQ*WIDTH-1:0] data;
  logic [NUM_REQ-1:0]       ack;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_in;

  modport master (
    output req, last, data, fifo_full,
    input  ack, fifo_wr_en, fifo_in
  );

  modport slave (
    input  req, last, data, fifo_full,
    output ack, fifo_wr_en, fifo_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding one FIFO write port.
// A granted requester owns the FIFO until its last beat or until MAX_BEATS beats have been written.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_busy,
  output logic               o_pkt_done,
  output logic               o_err_overlong
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rrPtr;
  logic [CNT_W-1:0]   r_beatCnt;
  logic               r_pktDone;
  logic               r_errOverlong;

  logic               w_anyReq;
  logic [IDX_W-1:0]   w_pick;
  logic [WIDTH-1:0]   w_slices [NUM_REQ];
  logic               w_ownerReq;
  logic               w_ownerLast;
  logic               w_xfer;
  logic               w_atLimit;
  logic               w_release;
  logic [IDX_W-1:0]   w_nextPtr;

  // Scan downward so the requester closest to (at or after) r_rrPtr wins.
  always_comb begin
    logic [IDX_W:0] sum;
    w_anyReq = 1'b0;
    w_pick   = '0;
    sum      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, r_rrPtr} + (IDX_W+1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      if (bus.req[sum[IDX_W-1:0]]) begin
        w_anyReq = 1'b1;
        w_pick   = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_slices[i] = bus.data[i*WIDTH +: WIDTH];
    end
  end

  assign w_ownerReq  = bus.req[r_owner];
  assign w_ownerLast = bus.last[r_owner];
  assign w_xfer      = (r_state == BUSY) && w_ownerReq && !bus.fifo_full;
  assign w_atLimit   = (r_beatCnt == LIMIT_CNT);
  assign w_release   = w_xfer && (w_ownerLast || w_atLimit);
  assign w_nextPtr   = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

  assign bus.fifo_wr_en = w_xfer;
  assign bus.ack        = w_xfer ? r_grant : '0;
  assign bus.fifo_in    = w_xfer ? w_slices[r_owner] : '0;

  assign o_grant        = r_grant;
  assign o_busy         = (r_state == BUSY);
  assign o_pkt_done     = r_pktDone;
  assign o_err_overlong = r_errOverlong;

  // Ownership FSM; a stalled owner keeps the FIFO indefinitely, there is no timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_rrPtr       <= '0;
      r_beatCnt     <= '0;
      r_pktDone     <= 1'b0;
      r_errOverlong <= 1'b0;
    end else begin
      r_pktDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state   <= BUSY;
            r_owner   <= w_pick;
            r_grant   <= NUM_REQ'(1) << w_pick;
            r_beatCnt <= '0;
          end
        end
        BUSY: begin
          if (w_xfer) begin
            r_beatCnt <= r_beatCnt + 1'b1;
            if (w_release) begin
              r_state   <= IDLE;
              r_grant   <= '0;
              r_rrPtr   <= w_nextPtr;
              r_pktDone <= 1'b1;
              if (!w_ownerLast) begin
                r_errOverlong <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_noWriteWhenFull: assert property (@(posedge clk) disable iff (reset)
    !(bus.fifo_wr_en && bus.fifo_full));
  a_grantOneHot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(r_grant));
  a_busyHasGrant: assert property (@(posedge clk) disable iff (reset)
    (r_state == BUSY) == (r_grant != '0));

endmodule
